// File: rtl/pipe_pkg.sv
// Shared pipeline types for the hazard controller: in-flight stage entry,
// forward-select codes and the register-index width.
package pipe_pkg;

    localparam int REG_AW        = 5;
    localparam int FWD_SEL_RF    = 0;
    localparam int FWD_SEL_EXMEM = 1;
    localparam int FWD_SEL_MEMWB = 2;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
    } stage_t;

    // x0 is hard-wired zero, so it never produces a hazard.
    function automatic logic entry_hits(input stage_t e, input logic [REG_AW-1:0] r);
        return e.valid && e.regwrite && (e.rd == r) && (r != '0);
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Youngest-match priority encoder over post-EX stages 1..FWD_DEPTH for one
// EX source operand; returns the stage number to forward from, or 0.
module hazard_match
    import pipe_pkg::*;
#(
    parameter int FWD_DEPTH = 2,
    parameter int LOAD_LAT  = 1,
    parameter int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
    input  stage_t [FWD_DEPTH:1] ents,
    input  logic [REG_AW-1:0]    src,
    input  logic                 use_src,
    output logic [SEL_W-1:0]     sel
);

    // Scan oldest to youngest so the youngest eligible hit is the last write.
    always_comb begin
        sel = SEL_W'(FWD_SEL_RF);
        if (use_src) begin
            for (int k = FWD_DEPTH; k >= 1; k--) begin
                if (entry_hits(ents[k], src) && !(ents[k].memread && k < LOAD_LAT)) begin
                    sel = SEL_W'(k);
                end
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Shadow-pipeline hazard controller: EX forwarding selects, load-use stall and
// branch flush. Define HAZ_STATS_EN to add saturating stall/flush counters.
module hazard_ctrl #(
    parameter int REG_AW    = pipe_pkg::REG_AW,
    parameter int FWD_DEPTH = 2,
    parameter int LOAD_LAT  = 1,
    parameter int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              ex_branch_taken,
    output logic              stall_o,
    output logic              flush_ifid_o,
    output logic              flush_idex_o,
    output logic [SEL_W-1:0]  fwd_a_o,
    output logic [SEL_W-1:0]  fwd_b_o
`ifdef HAZ_STATS_EN
    ,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       flush_cnt_o
`endif
);
    import pipe_pkg::*;

    // ents[0] is the instruction in EX, ents[k] is k stages past EX.
    stage_t [FWD_DEPTH:0] ents;
    logic [REG_AW-1:0]    ex_rs1;
    logic [REG_AW-1:0]    ex_rs2;
    logic                 ex_use1;
    logic                 ex_use2;
    logic                 load_hit;

    always_comb begin
        load_hit = 1'b0;
        for (int j = 0; j < LOAD_LAT; j++) begin
            if (ents[j].memread &&
                ((id_use_rs1 && entry_hits(ents[j], id_rs1)) ||
                 (id_use_rs2 && entry_hits(ents[j], id_rs2)))) begin
                load_hit = 1'b1;
            end
        end
    end

    assign stall_o      = id_valid && !ex_branch_taken && load_hit;
    assign flush_ifid_o = ex_branch_taken;
    assign flush_idex_o = ex_branch_taken;

    always_ff @(posedge clk) begin
        if (rst) begin
            ents    <= '0;
            ex_rs1  <= '0;
            ex_rs2  <= '0;
            ex_use1 <= 1'b0;
            ex_use2 <= 1'b0;
        end else begin
            for (int k = 1; k <= FWD_DEPTH; k++) begin
                ents[k] <= ents[k-1];
            end
            if (ex_branch_taken || stall_o) begin
                ents[0] <= '0;
                ex_use1 <= 1'b0;
                ex_use2 <= 1'b0;
            end else begin
                ents[0] <= '{valid: id_valid, rd: id_rd, regwrite: id_regwrite, memread: id_memread};
                ex_rs1  <= id_rs1;
                ex_rs2  <= id_rs2;
                // An empty ID slot must not turn into a forwarding consumer.
                ex_use1 <= id_valid && id_use_rs1;
                ex_use2 <= id_valid && id_use_rs2;
            end
        end
    end

    hazard_match #(.FWD_DEPTH(FWD_DEPTH), .LOAD_LAT(LOAD_LAT), .SEL_W(SEL_W)) u_match_a (
        .ents    (ents[FWD_DEPTH:1]),
        .src     (ex_rs1),
        .use_src (ex_use1),
        .sel     (fwd_a_o)
    );

    hazard_match #(.FWD_DEPTH(FWD_DEPTH), .LOAD_LAT(LOAD_LAT), .SEL_W(SEL_W)) u_match_b (
        .ents    (ents[FWD_DEPTH:1]),
        .src     (ex_rs2),
        .use_src (ex_use2),
        .sel     (fwd_b_o)
    );

`ifdef HAZ_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (stall_o && stall_cnt_o != 32'hFFFF_FFFF) stall_cnt_o <= stall_cnt_o + 32'd1;
            if (ex_branch_taken && flush_cnt_o != 32'hFFFF_FFFF) flush_cnt_o <= flush_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// traffic against an age-based model of in-flight instructions.
module tb_hazard_ctrl;

    localparam int AW        = 5;
    localparam int FWD_DEPTH = 2;
    localparam int LOAD_LAT  = 1;
    localparam int SEL_W     = $clog2(FWD_DEPTH + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_memread, ex_branch_taken;
    logic [AW-1:0] id_rs1, id_rs2, id_rd;
    logic stall_o, flush_ifid_o, flush_idex_o;
    logic [SEL_W-1:0] fwd_a_o, fwd_b_o;
`ifdef HAZ_STATS_EN
    logic [31:0] stall_cnt_o, flush_cnt_o;
`endif

    hazard_ctrl #(.REG_AW(AW), .FWD_DEPTH(FWD_DEPTH), .LOAD_LAT(LOAD_LAT), .SEL_W(SEL_W)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .ex_branch_taken(ex_branch_taken),
        .stall_o(stall_o), .flush_ifid_o(flush_ifid_o), .flush_idex_o(flush_idex_o),
        .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o)
`ifdef HAZ_STATS_EN
        , .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Model: every instruction that reached EX, tagged with the cycle it entered EX.
    typedef struct {
        int            enter;
        logic [AW-1:0] rd;
        logic          rw;
        logic          mr;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic          u1;
        logic          u2;
    } rec_t;
    rec_t hist[$];
    int   cyc = 0;
    int   m_stall_cnt = 0;
    int   m_flush_cnt = 0;
    logic exp_stall, exp_flush;
    logic [SEL_W-1:0] exp_fa, exp_fb;

    task automatic drive(input logic v, input logic [AW-1:0] rd, input logic rw, input logic mr,
                         input logic [AW-1:0] rs1, input logic u1, input logic [AW-1:0] rs2,
                         input logic u2, input logic br);
        id_valid = v; id_rd = rd; id_regwrite = rw; id_memread = mr;
        id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
        ex_branch_taken = br;
    endtask

    task automatic nop();
        drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic calc();
        int ex_idx, s, ba, bb;
        bit hz;
        exp_flush = ex_branch_taken;
        hz = 0; ex_idx = -1; ba = 0; bb = 0;
        foreach (hist[i]) begin
            s = cyc - hist[i].enter;
            if (s == 0) ex_idx = i;
            if (s < LOAD_LAT && hist[i].mr && hist[i].rw && hist[i].rd != 0 &&
                ((id_use_rs1 && hist[i].rd == id_rs1) || (id_use_rs2 && hist[i].rd == id_rs2)))
                hz = 1;
        end
        exp_stall = id_valid && !ex_branch_taken && hz;
        if (ex_idx >= 0) begin
            foreach (hist[i]) begin
                s = cyc - hist[i].enter;
                if (s >= 1 && s <= FWD_DEPTH && hist[i].rw && !(hist[i].mr && s < LOAD_LAT)) begin
                    if (hist[ex_idx].u1 && hist[ex_idx].rs1 != 0 && hist[i].rd == hist[ex_idx].rs1 && (ba == 0 || s < ba)) ba = s;
                    if (hist[ex_idx].u2 && hist[ex_idx].rs2 != 0 && hist[i].rd == hist[ex_idx].rs2 && (bb == 0 || s < bb)) bb = s;
                end
            end
        end
        exp_fa = SEL_W'(ba);
        exp_fb = SEL_W'(bb);
    endtask

    task automatic advance();
        rec_t r;
        calc();
        @(posedge clk);
        cyc++;
        if (rst) begin
            hist.delete();
            m_stall_cnt = 0;
            m_flush_cnt = 0;
        end else begin
            if (exp_stall) m_stall_cnt++;
            if (ex_branch_taken) m_flush_cnt++;
            if (id_valid && !ex_branch_taken && !exp_stall) begin
                r = '{enter: cyc, rd: id_rd, rw: id_regwrite, mr: id_memread,
                      rs1: id_rs1, rs2: id_rs2, u1: id_use_rs1, u2: id_use_rs2};
                hist.push_back(r);
            end
            while (hist.size() > 0 && cyc - hist[0].enter > FWD_DEPTH) void'(hist.pop_front());
        end
        #1;
    endtask

    task automatic settle();
        rst = 1'b0;
        nop();
        repeat (FWD_DEPTH + 1) advance();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        nop();
        advance();
        advance();
        rst = 1'b0;
        drive(1'b1, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 5'd5, 1'b1, 1'b0);
        #1;
        checks++;
        if ({stall_o, flush_ifid_o, flush_idex_o, fwd_a_o, fwd_b_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%b required=0", {stall_o, flush_ifid_o, flush_idex_o, fwd_a_o, fwd_b_o});
        end
`ifdef HAZ_STATS_EN
        checks++;
        if ({stall_cnt_o, flush_cnt_o} !== 64'd0) begin
            errors++;
            $display("FAIL reset_counters got=%0d/%0d required=0/0", stall_cnt_o, flush_cnt_o);
        end
`endif
        advance();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 5'd5, 1'b1, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0);   // add x5,x1,x2
        #1;
        checks++;
        if (stall_o !== 1'b0) begin errors++; $display("FAIL b2b_stall_add got=%b required=0", stall_o); end
        advance();
        drive(1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0);   // sub x6,x5,x7
        #1;
        checks++;
        if (stall_o !== 1'b0) begin errors++; $display("FAIL b2b_stall_sub got=%b required=0", stall_o); end
        advance();
        nop();
        #1;
        checks++;
        if ({stall_o, fwd_a_o, fwd_b_o} !== {1'b0, SEL_W'(1), SEL_W'(0)}) begin
            errors++;
            $display("FAIL b2b_fwd got stall=%b a=%0d b=%0d required stall=0 a=1 b=0", stall_o, fwd_a_o, fwd_b_o);
        end
        advance();
    endtask

    task automatic test_two_apart();
        drive(1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); advance();
        drive(1'b1, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); advance();
        drive(1'b1, 5'd10, 1'b1, 1'b0, 5'd3, 1'b1, 5'd5, 1'b1, 1'b0); advance();
        nop();
        #1;
        checks++;
        if ({fwd_a_o, fwd_b_o} !== {SEL_W'(0), SEL_W'(2)}) begin
            errors++;
            $display("FAIL two_apart got a=%0d b=%0d required a=0 b=2", fwd_a_o, fwd_b_o);
        end
        advance();
        drive(1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); advance();
        drive(1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); advance();
        drive(1'b1, 5'd10, 1'b1, 1'b0, 5'd3, 1'b1, 5'd5, 1'b1, 1'b0); advance();
        nop();
        #1;
        checks++;
        if (fwd_b_o !== SEL_W'(1)) begin
            errors++;
            $display("FAIL youngest_wins got b=%0d required b=1", fwd_b_o);
        end
        advance();
    endtask

    task automatic test_load_use();
        drive(1'b1, 5'd8, 1'b1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0);   // lw x8
        #1;
        checks++;
        if (stall_o !== 1'b0) begin errors++; $display("FAIL lu_stall_lw got=%b required=0", stall_o); end
        advance();
        drive(1'b1, 5'd9, 1'b1, 1'b0, 5'd8, 1'b1, 5'd8, 1'b1, 1'b0);   // add x9,x8,x8
        #1;
        checks++;
        if (stall_o !== 1'b1) begin errors++; $display("FAIL lu_stall_first got=%b required=1", stall_o); end
        advance();
        #1;
        checks++;
        if (stall_o !== 1'b0) begin errors++; $display("FAIL lu_stall_release got=%b required=0", stall_o); end
        advance();
        nop();
        #1;
        checks++;
        if ({fwd_a_o, fwd_b_o} !== {SEL_W'(2), SEL_W'(2)}) begin
            errors++;
            $display("FAIL lu_fwd got a=%0d b=%0d required a=2 b=2", fwd_a_o, fwd_b_o);
        end
        advance();
    endtask

    task automatic test_x0();
        drive(1'b1, 5'd0, 1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0); advance();   // lw x0
        drive(1'b1, 5'd4, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0);
        #1;
        checks++;
        if (stall_o !== 1'b0) begin errors++; $display("FAIL x0_stall got=%b required=0", stall_o); end
        advance();
        drive(1'b1, 5'd0, 1'b1, 1'b0, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0); advance();   // addi x0
        drive(1'b1, 5'd4, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0); advance();
        nop();
        #1;
        checks++;
        if ({stall_o, fwd_a_o, fwd_b_o} !== '0) begin
            errors++;
            $display("FAIL x0_fwd got a=%0d b=%0d required a=0 b=0", fwd_a_o, fwd_b_o);
        end
        advance();
    endtask

    task automatic test_branch_flush();
        drive(1'b1, 5'd8, 1'b1, 1'b1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0); advance();   // lw x8
        drive(1'b1, 5'd9, 1'b1, 1'b0, 5'd8, 1'b1, 5'd8, 1'b1, 1'b1);
        #1;
        checks++;
        if ({stall_o, flush_ifid_o, flush_idex_o} !== 3'b011) begin
            errors++;
            $display("FAIL br_flush got stall/ifid/idex=%b required=011", {stall_o, flush_ifid_o, flush_idex_o});
        end
        advance();
        nop();
        #1;
        checks++;
        if ({flush_ifid_o, fwd_a_o, fwd_b_o} !== '0) begin
            errors++;
            $display("FAIL br_bubble got flush=%b a=%0d b=%0d required 0", flush_ifid_o, fwd_a_o, fwd_b_o);
        end
        advance();
        #1;
        checks++;
        if ({fwd_a_o, fwd_b_o} !== '0) begin
            errors++;
            $display("FAIL br_no_spurious got a=%0d b=%0d required 0", fwd_a_o, fwd_b_o);
        end
        advance();
    endtask

    task automatic test_reset_midstream();
        drive(1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); advance();
        drive(1'b1, 5'd6, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); advance();
        drive(1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); advance();
        rst = 1'b1;
        drive(1'b1, 5'd10, 1'b1, 1'b0, 5'd7, 1'b1, 5'd5, 1'b1, 1'b0);
        advance();
        rst = 1'b0;
        #1;
        checks++;
        if ({stall_o, fwd_a_o, fwd_b_o} !== '0) begin
            errors++;
            $display("FAIL mid_rst_now got stall=%b a=%0d b=%0d required 0", stall_o, fwd_a_o, fwd_b_o);
        end
`ifdef HAZ_STATS_EN
        checks++;
        if ({stall_cnt_o, flush_cnt_o} !== 64'd0) begin
            errors++;
            $display("FAIL mid_rst_counters got=%0d/%0d required=0/0", stall_cnt_o, flush_cnt_o);
        end
`endif
        advance();
        nop();
        #1;
        checks++;
        if ({fwd_a_o, fwd_b_o} !== '0) begin
            errors++;
            $display("FAIL mid_rst_next got a=%0d b=%0d required 0", fwd_a_o, fwd_b_o);
        end
        advance();
    endtask

    task automatic test_random();
        logic held;
        logic v, rw, mr, u1, u2, br;
        logic [AW-1:0] rd, rs1, rs2;
        held = 1'b0;
        v = 0; rw = 0; mr = 0; u1 = 0; u2 = 0; rd = 0; rs1 = 0; rs2 = 0;
        rst = 1'b1; nop(); advance(); rst = 1'b0;
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            if (!held) begin
                v   = ($urandom_range(0, 7) != 0);
                rd  = AW'($urandom_range(0, 7));
                rw  = ($urandom_range(0, 3) != 0);
                mr  = ($urandom_range(0, 2) == 0);
                rs1 = AW'($urandom_range(0, 7));
                rs2 = AW'($urandom_range(0, 7));
                u1  = ($urandom_range(0, 3) != 0);
                u2  = ($urandom_range(0, 1) != 0);
            end
            br = ($urandom_range(0, 7) == 0);
            drive(v, rd, rw, mr, rs1, u1, rs2, u2, br);
            #1;
            calc();
            checks++;
            if ({stall_o, flush_ifid_o, flush_idex_o, fwd_a_o, fwd_b_o} !==
                {exp_stall, exp_flush, exp_flush, exp_fa, exp_fb}) begin
                errors++;
                $display("FAIL rand_cycle%0d got stall=%b flush=%b%b a=%0d b=%0d required stall=%b flush=%b a=%0d b=%0d",
                         i, stall_o, flush_ifid_o, flush_idex_o, fwd_a_o, fwd_b_o,
                         exp_stall, exp_flush, exp_fa, exp_fb);
            end
`ifdef HAZ_STATS_EN
            checks++;
            if (stall_cnt_o !== 32'(m_stall_cnt) || flush_cnt_o !== 32'(m_flush_cnt)) begin
                errors++;
                $display("FAIL rand_counters%0d got=%0d/%0d required=%0d/%0d",
                         i, stall_cnt_o, flush_cnt_o, m_stall_cnt, m_flush_cnt);
            end
`endif
            held = exp_stall && !rst;
            advance();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        nop();
        test_reset();
        settle();
        test_back_to_back();
        settle();
        test_two_apart();
        settle();
        test_load_use();
        settle();
        test_x0();
        settle();
        test_branch_flush();
        settle();
        test_reset_midstream();
        settle();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
